// File: rtl/keypad_timer_pkg.sv
// Shared types and helpers for the keypad timer entry controller.
// Holds the FSM state encoding, the key code width and the one-hot key decoder.
package keypad_timer_pkg;

  localparam int CODE_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_LOAD,
    ST_HOLD,
    ST_ERR
  } kp_state_t;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              one;
    logic              multi;
  } key_dec_t;

  // Highest set bit wins the code; the popcount is what decides validity.
  function automatic key_dec_t onehot_to_code(input logic [15:0] keys);
    key_dec_t    r;
    int unsigned n;
    r = '0;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (keys[i]) begin
        n++;
        r.code = CODE_W'(i);
      end
    end
    r.one   = (n == 1);
    r.multi = (n > 1);
    return r;
  endfunction

endpackage

// File: rtl/keypad_timer_entry_ctrl_timebase_div.sv
// Free-running divider producing a 50% duty timebase and a tick on its rising edge.
// Outputs are registered and aligned to the counter value loaded on the same edge.
module timebase_div #(
  parameter int CLK_DIV = 100
) (
  input  logic clk,
  input  logic rst,
  output logic pgt_1Hz,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLK_DIV / 2);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_pgt;
  logic             r_tick;

  assign w_cnt_nxt = (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);

  // Flags are computed from the next count so they line up with r_cnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_pgt  <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_pgt  <= (w_cnt_nxt >= HALF);
      r_tick <= (w_cnt_nxt == HALF);
    end
  end

  assign pgt_1Hz = r_pgt;
  assign tick    = r_tick;

endmodule

// File: rtl/keypad_timer_entry_ctrl.sv
// Keypad debounce/encode with BCD entry shift register, multi-key flag and 1 Hz timebase.
// A key stable from edge 1 strobes loadn low between edges DEBOUNCE_CYCLES+1 and +2.
module keypad_timer_entry_ctrl
  import keypad_timer_pkg::*;
#(
  parameter int NUM_KEYS        = 10,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CLK_DIV         = 100,
  parameter int DIGITS          = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_KEYS-1:0]   keypad,
  input  logic                  enablen,
  input  logic                  clear_entry,
  output logic [CODE_W-1:0]     D,
  output logic                  loadn,
  output logic [4*DIGITS-1:0]   entry,
  output logic                  entry_valid,
  output logic                  multi_key_err,
  output logic                  pgt_1Hz,
  output logic                  tick
);

  localparam int ENTRY_W = CODE_W * DIGITS;
  localparam int CNT_W   = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEB_N = CNT_W'(DEBOUNCE_CYCLES);

  kp_state_t          r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [CODE_W-1:0]  r_code, w_code_nxt;
  logic [CODE_W-1:0]  r_d;
  logic               r_loadn;
  logic [ENTRY_W-1:0] r_entry;
  logic [ENTRY_W-1:0] w_shift;
  logic               r_valid;
  logic               r_err;
  logic               w_zero;
  logic               w_done;
  logic               w_load;
  key_dec_t           w_dec;

  assign w_dec     = onehot_to_code(16'(keypad));
  assign w_zero    = (keypad == '0);
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_done    = (w_cnt_inc == DEB_N);
  assign w_load    = (r_state == ST_LOAD) && !enablen;

  if (DIGITS == 1) begin : g_one_digit
    assign w_shift = r_code;
  end else begin : g_multi_digit
    assign w_shift = {r_entry[ENTRY_W-CODE_W-1:0], r_code};
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_code_nxt  = r_code;
    if (enablen) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DEBOUNCE: begin
          if (w_dec.multi) begin
            w_state_nxt = ST_ERR;
            w_cnt_nxt   = '0;
          end else if (w_zero) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else if (r_state == ST_DEBOUNCE && w_dec.code == r_code) begin
            if (w_done) begin
              w_state_nxt = ST_LOAD;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else begin
            // Fresh or changed key: this sample is the first of the run.
            w_code_nxt  = w_dec.code;
            w_state_nxt = (DEBOUNCE_CYCLES == 1) ? ST_LOAD : ST_DEBOUNCE;
            w_cnt_nxt   = (DEBOUNCE_CYCLES == 1) ? '0 : CNT_W'(1);
          end
        end
        ST_LOAD: begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = '0;
        end
        ST_HOLD, ST_ERR: begin
          if (!w_zero) begin
            w_cnt_nxt = '0;
          end else if (w_done) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_code  <= '0;
      r_d     <= '0;
      r_loadn <= 1'b1;
      r_entry <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_code  <= w_code_nxt;
      r_err   <= (w_state_nxt == ST_ERR);
      r_loadn <= !w_load;
      if (w_load) begin
        r_d     <= r_code;
        r_valid <= 1'b1;
        // A coincident clear wipes the old digits before the shift.
        r_entry <= clear_entry ? ENTRY_W'(r_code) : w_shift;
      end else if (clear_entry) begin
        r_entry <= '0;
        r_valid <= 1'b0;
      end
    end
  end

  assign D             = r_d;
  assign loadn         = r_loadn;
  assign entry         = r_entry;
  assign entry_valid   = r_valid;
  assign multi_key_err = r_err;

  timebase_div #(
    .CLK_DIV(CLK_DIV)
  ) u_timebase (
    .clk    (clk),
    .rst    (rst),
    .pgt_1Hz(pgt_1Hz),
    .tick   (tick)
  );

endmodule

// File: doc/keypad_timer_entry_ctrl.md
Name: keypad_timer_entry_ctrl

Overview:
Parametrised successor to the microwave timer keypad encoder. It debounces a one-hot keypad and encodes each accepted key to a 4-bit code with a single-cycle active-low load strobe. It also accumulates a DIGITS-long BCD entry by shift-in, flags multi-key presses, and generates the 1 Hz timebase (square wave plus tick pulse) from the system clock. It sits between the keypad and the timer/counter datapath.

Parameters:
NUM_KEYS, 10, keypad width; key i encodes to value i; legal range 1..16
DEBOUNCE_CYCLES, 4, consecutive identical samples required to accept a press or a release; at least 1
CLK_DIV, 100, clk cycles per timebase period; must be even and at least 2
DIGITS, 4, number of 4-bit digits held in the entry register; at least 1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
keypad  input  NUM_KEYS  raw key lines, active-high, expected one-hot or zero
enablen  input  1  active-low entry enable
clear_entry  input  1  synchronous clear of the entry register
D  output  4  code of the last accepted key
loadn  output  1  active-low, one-cycle strobe per accepted key
entry  output  4*DIGITS  accumulated digits; newest digit in bits [3:0]
entry_valid  output  1  high once at least one digit has loaded since reset or the last clear
multi_key_err  output  1  high while a multi-key condition is latched
pgt_1Hz  output  1  square wave, CLK_DIV/2 cycles high, then CLK_DIV/2 cycles low
tick  output  1  one-cycle pulse coincident with each rising edge of pgt_1Hz

Behaviour:
- Reset (async, rst=1): D=0, loadn=1, entry=0, entry_valid=0, multi_key_err=0, pgt_1Hz=0, tick=0. FSM goes to IDLE and all counters go to 0.
- FSM states: IDLE, DEBOUNCE, LOAD, HOLD, ERR.
- IDLE:
  - keypad==0: stay in IDLE.
  - Exactly one bit set: go to DEBOUNCE, capture the code, set cnt=1.
  - More than one bit set: go to ERR.
- DEBOUNCE:
  - Same code sampled: cnt++. When cnt reaches DEBOUNCE_CYCLES, go to LOAD.
  - Different single key: restart with the new code, cnt=1.
  - keypad==0: go to IDLE.
  - More than one bit set: go to ERR.
- LOAD (exactly one cycle):
  - loadn=0 and D=code.
  - entry <= {entry[4*DIGITS-5:0], code}. The oldest digit is discarded, i.e. wrap without error.
  - entry_valid <= 1. Next state is HOLD.
- Press latency: a key stable from edge 1 drives loadn low between edge DEBOUNCE_CYCLES+1 and edge DEBOUNCE_CYCLES+2.
- HOLD: wait until keypad==0 for DEBOUNCE_CYCLES consecutive samples, then go to IDLE. Any other keypad value resets the release counter. Key auto-repeat is never produced.
- ERR:
  - multi_key_err=1, and no load occurs.
  - Exit to IDLE after keypad==0 for DEBOUNCE_CYCLES consecutive samples; multi_key_err clears on that transition.
- enablen=1:
  - FSM is forced to IDLE and counters clear; loadn=1.
  - entry and D hold; multi_key_err clears.
  - Holding a key while enablen falls counts as a fresh press.
- clear_entry:
  - Sets entry=0 and entry_valid=0 on the next edge.
  - If coincident with LOAD, the clear applies first, then the shift: entry={0…,code} and entry_valid=1.
- Timebase:
  - A free-running counter 0..CLK_DIV-1, independent of enablen and keypad.
  - pgt_1Hz=1 while the counter is in CLK_DIV/2..CLK_DIV-1.
  - tick=1 in the cycle where the counter equals CLK_DIV/2.
  - First tick occurs CLK_DIV/2 cycles after reset release.
- All outputs are registered. There are no combinational paths from input to output.

Decomposition:
- Package keypad_timer_pkg holds:
  - the state enum;
  - the 4-bit code width constant;
  - a function onehot_to_code with a popcount/multi-hot check.
- One sub-module, timebase_div: parametrised by CLK_DIV; ports clk, rst, pgt_1Hz, tick.
- The FSM, debounce and entry register live in the top level.

Test Plan:
- Defaults, keys 0..9 each held 20 cycles with 20 cycles released -> ten loadn pulses, each exactly 1 cycle wide; D=0..9 in order; entry ends at 0x6789; entry_valid=1.
- Key 7 held 2 cycles, then released (glitch shorter than DEBOUNCE_CYCLES) -> no loadn, entry unchanged.
- keypad=0x080, then 0x084 before acceptance -> multi_key_err=1, no load. Release for 4 cycles -> multi_key_err=0, state IDLE.
- Key 3 held 50 cycles -> exactly one loadn pulse, asserted between edge 5 and edge 6 after the key is applied.
- clear_entry pulsed in the LOAD cycle of key 5, with entry=0x1234 beforehand -> entry=0x0005, entry_valid=1. enablen=1 mid-DEBOUNCE -> no load.
- rst asserted mid-HOLD, plus a CLK_DIV=100 run of 300 cycles -> all outputs at reset values immediately; tick at cycles 50, 150, 250; pgt_1Hz 50 cycles high, 50 cycles low.
